// File: rtl/backbone_initial_pkg.sv
// Shared types and helpers for the backbone_initial sequencer.
package backbone_initial_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    // Result substituted when the engine never answers
    localparam logic [63:0] QNAN = 64'h7FF8000000000000;

    // ind_j must hold J itself, hence the extra bit
    function automatic int j_width(input int j);
        return $clog2(j) + 1;
    endfunction

    function automatic int a_width(input int a);
        return $clog2(a) + 1;
    endfunction

endpackage

// File: rtl/backbone_initial_ctrl.sv
// Sequencer in front of one backbone_initial engine: accepts a job, pulses
// the engine once per ind_j in [j_first, j_last], and streams the results out
// in order over a ready/valid port.
// Optional: define BACKBONE_INITIAL_CTRL_TIMEOUT_EN to bound the wait for an
// engine result by TIMEOUT_CYC cycles (a quiet NaN is emitted on expiry).
module backbone_initial_ctrl
    import backbone_initial_pkg::*;
#(
    parameter int J           = 14,
    parameter int I           = 7,
    parameter int A           = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       job_tvalid,
    output logic                       job_tready,
    input  logic [J*A*64-1:0]          job_alpha_u,
    input  logic [J*a_width(A)-1:0]    job_x_initial,
    input  logic [j_width(J)-1:0]      job_j_first,
    input  logic [j_width(J)-1:0]      job_j_last,
    output logic [J*A*64-1:0]          eng_alpha_u,
    output logic                       eng_alpha_u_tvalid,
    output logic [J*a_width(A)-1:0]    eng_x_initial,
    output logic                       eng_x_initial_tvalid,
    output logic [j_width(J)-1:0]      eng_ind_j,
    output logic                       eng_ind_j_tvalid,
    input  logic                       eng_result_tvalid,
    input  logic [63:0]                eng_result,
    output logic                       res_tvalid,
    input  logic                       res_tready,
    output logic [63:0]                res_data,
    output logic [j_width(J)-1:0]      res_ind_j,
    output logic                       res_last,
    output logic                       busy,
    output logic                       err
);

    localparam int J_WIDTH = j_width(J);
    localparam int A_WIDTH = a_width(A);
    localparam int X_WIDTH = J * A_WIDTH;

    // I only mirrors the engine's configuration; reject nonsense values early
    if (J < 1 || I < 1 || A < 1 || TIMEOUT_CYC < 1) begin : g_cfg_chk
        $error("backbone_initial_ctrl: J, I, A and TIMEOUT_CYC must be >= 1");
    end

    state_e               state_q, state_d;
    logic [J*A*64-1:0]    alpha_q, alpha_d;
    logic [X_WIDTH-1:0]   x_q, x_d;
    logic [J_WIDTH-1:0]   j_last_q, j_last_d;
    logic [J_WIDTH-1:0]   cur_j_q, cur_j_d;
    logic [J_WIDTH-1:0]   res_ind_j_q, res_ind_j_d;
    logic [63:0]          res_data_q, res_data_d;
    logic                 res_last_q, res_last_d;
    logic                 err_q, err_d;
    logic                 job_ok;

`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]        tmo_q, tmo_d;
`endif

    assign job_ok = (job_j_first != '0) && (job_j_first <= job_j_last) &&
                    (job_j_last <= J_WIDTH'(J));

    // Next-state and datapath decisions
    always_comb begin
        state_d     = state_q;
        alpha_d     = alpha_q;
        x_d         = x_q;
        j_last_d    = j_last_q;
        cur_j_d     = cur_j_q;
        res_ind_j_d = res_ind_j_q;
        res_data_d  = res_data_q;
        res_last_d  = res_last_q;
        err_d       = err_q;
`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        // a result nobody asked for is a protocol error, never captured
        if (eng_result_tvalid && state_q != S_WAIT) err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (job_tvalid) begin
                    alpha_d  = job_alpha_u;
                    x_d      = job_x_initial;
                    j_last_d = job_j_last;
                    if (job_ok) begin
                        cur_j_d = job_j_first;
                        state_d = S_ISSUE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
                tmo_d   = '0;
`endif
            end
            S_WAIT: begin
                if (eng_result_tvalid) begin
                    res_data_d  = eng_result;
                    res_ind_j_d = cur_j_q;
                    res_last_d  = (cur_j_q == j_last_q);
                    state_d     = S_OUT;
                end
`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
                else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    res_data_d  = QNAN;
                    res_ind_j_d = cur_j_q;
                    res_last_d  = (cur_j_q == j_last_q);
                    err_d       = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_OUT: begin
                if (res_tready) begin
                    if (res_last_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cur_j_d = cur_j_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and job registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alpha_q     <= '0;
            x_q         <= '0;
            j_last_q    <= '0;
            cur_j_q     <= '0;
            res_ind_j_q <= '0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            alpha_q     <= alpha_d;
            x_q         <= x_d;
            j_last_q    <= j_last_d;
            cur_j_q     <= cur_j_d;
            res_ind_j_q <= res_ind_j_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
            err_q       <= err_d;
`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign job_tready           = (state_q == S_IDLE);
    assign busy                 = (state_q != S_IDLE);
    assign eng_alpha_u          = alpha_q;
    assign eng_x_initial        = x_q;
    assign eng_ind_j            = cur_j_q;
    assign eng_alpha_u_tvalid   = (state_q == S_ISSUE);
    assign eng_x_initial_tvalid = (state_q == S_ISSUE);
    assign eng_ind_j_tvalid     = (state_q == S_ISSUE);
    assign res_tvalid           = (state_q == S_OUT);
    assign res_data             = res_data_q;
    assign res_ind_j            = res_ind_j_q;
    assign res_last             = res_last_q;
    assign err                  = err_q;

endmodule

// File: tb/tb_backbone_initial_ctrl.sv
// Bench for backbone_initial_ctrl: table of jobs plus random jobs, checked
// against a per-job list of expected results; engine stub answers ind_j as a
// double three cycles after each issue pulse.
module tb_backbone_initial_ctrl;

    localparam int J  = 14;
    localparam int A  = 2;
    localparam int JW = 5;
    localparam int AW = 2;
    localparam logic [63:0] NAN = 64'h7FF8000000000000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              job_tvalid = 1'b0;
    logic              job_tready;
    logic [J*A*64-1:0] alpha = '0;
    logic [J*AW-1:0]   xsel = '0;
    logic [JW-1:0]     job_j_first = '0;
    logic [JW-1:0]     job_j_last = '0;
    logic [J*A*64-1:0] eng_alpha_u;
    logic              eng_alpha_u_tvalid;
    logic [J*AW-1:0]   eng_x_initial;
    logic              eng_x_initial_tvalid;
    logic [JW-1:0]     eng_ind_j;
    logic              eng_ind_j_tvalid;
    logic              eng_result_tvalid;
    logic [63:0]       eng_result;
    logic              res_tvalid;
    logic              res_tready = 1'b0;
    logic [63:0]       res_data;
    logic [JW-1:0]     res_ind_j;
    logic              res_last;
    logic              busy;
    logic              err;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;
    int silent_j = -1;
    logic spur = 1'b0;

    always #5 clk = ~clk;

    backbone_initial_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .job_tvalid(job_tvalid), .job_tready(job_tready),
        .job_alpha_u(alpha), .job_x_initial(xsel),
        .job_j_first(job_j_first), .job_j_last(job_j_last),
        .eng_alpha_u(eng_alpha_u), .eng_alpha_u_tvalid(eng_alpha_u_tvalid),
        .eng_x_initial(eng_x_initial), .eng_x_initial_tvalid(eng_x_initial_tvalid),
        .eng_ind_j(eng_ind_j), .eng_ind_j_tvalid(eng_ind_j_tvalid),
        .eng_result_tvalid(eng_result_tvalid), .eng_result(eng_result),
        .res_tvalid(res_tvalid), .res_tready(res_tready),
        .res_data(res_data), .res_ind_j(res_ind_j), .res_last(res_last),
        .busy(busy), .err(err)
    );

    // Engine stub: three-cycle latency, answers real'(ind_j)
    logic [2:0]          sp_v;
    logic [2:0][JW-1:0]  sp_j;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_v <= '0;
            sp_j <= '0;
        end else begin
            sp_v <= {sp_v[1:0], eng_ind_j_tvalid && (int'(eng_ind_j) != silent_j)};
            sp_j <= {sp_j[1:0], eng_ind_j};
        end
    end
    assign eng_result_tvalid = sp_v[2] | spur;
    assign eng_result        = $realtobits(real'(sp_j[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_job_tready"}, 64'(job_tready), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_eng_tvalids"}, 64'({eng_alpha_u_tvalid, eng_x_initial_tvalid, eng_ind_j_tvalid}), 64'd0);
        chk({tag, "_eng_ind_j"}, 64'(eng_ind_j), 64'd0);
        chk({tag, "_res_tvalid"}, 64'(res_tvalid), 64'd0);
        chk({tag, "_res_data"}, res_data, 64'd0);
        chk({tag, "_res_ind_j_last"}, 64'({res_ind_j, res_last}), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_eng_alpha_zero"}, 64'(eng_alpha_u == '0 && eng_x_initial == '0), 64'd1);
    endtask

    function automatic logic [63:0] exp_val(input int j);
        return (j == silent_j) ? NAN : $realtobits(real'(j));
    endfunction

    // One job start to finish; exp_ok/exp_n come from the caller, result values from exp_val
    task automatic run_job(input int jf, input int jl, input int bp, input bit exp_ok, input int exp_n);
        int iss[$];
        logic [63:0] rd[$];
        int rj[$];
        bit rl[$];
        bit held = 0;
        logic [63:0] held_d = '0;
        int stall = 0;
        int cyc = 0;
        bit last_hs = 0;
        if (!exp_ok) exp_err = 1'b1;
        if (exp_ok && silent_j >= jf && silent_j <= jl) exp_err = 1'b1;
        @(negedge clk);
        chk("job_tready_idle", 64'(job_tready), 64'd1);
        job_tvalid  = 1'b1;
        job_j_first = jf[JW-1:0];
        job_j_last  = jl[JW-1:0];
        @(negedge clk);
        job_tvalid = 1'b0;
        chk("issue_after_accept", 64'(eng_ind_j_tvalid), 64'(exp_ok));
        chk("busy_after_accept", 64'(busy), 64'(exp_ok));
        if (exp_ok) begin
            chk("eng_alpha_latched", 64'(eng_alpha_u == alpha), 64'd1);
            chk("eng_x_latched", 64'(eng_x_initial == xsel), 64'd1);
        end
        while (busy && cyc < 2000) begin
            if (bp == 0) res_tready = 1'b1;
            else if (bp == 1) res_tready = 1'($urandom_range(0, 1));
            else begin
                if (res_tvalid && rd.size() == 0 && stall < 10) begin
                    res_tready = 1'b0;
                    stall++;
                end else res_tready = 1'b1;
            end
            if (eng_ind_j_tvalid) begin
                iss.push_back(int'(eng_ind_j));
                chk("tvalid_tie", 64'({eng_alpha_u_tvalid, eng_x_initial_tvalid}), 64'd3);
            end
            if (held) begin
                chk("hold_valid", 64'(res_tvalid), 64'd1);
                chk("hold_data", res_data, held_d);
            end
            if (res_tvalid) chk("no_issue_while_out", 64'(eng_ind_j_tvalid), 64'd0);
            if (res_tvalid && res_tready) begin
                rd.push_back(res_data);
                rj.push_back(int'(res_ind_j));
                rl.push_back(res_last);
                if (res_last) last_hs = 1;
                held = 0;
            end else if (res_tvalid) begin
                held = 1;
                held_d = res_data;
            end
            @(negedge clk);
            cyc++;
            if (last_hs) begin
                chk("busy_drop_after_last", 64'(busy), 64'd0);
                break;
            end
        end
        res_tready = 1'b0;
        if (cyc >= 2000) chk("job_cycle_budget", 64'(busy), 64'd0);
        if (!exp_ok) begin
            for (int k = 0; k < 4; k++) begin
                chk("no_pulse_invalid", 64'(eng_ind_j_tvalid), 64'd0);
                @(negedge clk);
            end
        end
        chk("issue_count", 64'(iss.size()), 64'(exp_n));
        chk("result_count", 64'(rd.size()), 64'(exp_n));
        for (int k = 0; k < exp_n && k < iss.size(); k++)
            chk("issue_ind_j", 64'(iss[k]), 64'(jf + k));
        for (int k = 0; k < exp_n && k < rd.size(); k++) begin
            chk("res_data", rd[k], exp_val(jf + k));
            chk("res_ind_j", 64'(rj[k]), 64'(jf + k));
            chk("res_last", 64'(rl[k]), 64'(k == exp_n - 1));
        end
        chk("err_flag", 64'(err), 64'(exp_err));
    endtask

    typedef struct {
        int jf;
        int jl;
        int bp;
        bit ok;
        int n;
    } job_t;

    job_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{jf: 1,  jl: 3,  bp: 0, ok: 1'b1, n: 3};
        tbl[1] = '{jf: 7,  jl: 7,  bp: 0, ok: 1'b1, n: 1};
        tbl[2] = '{jf: 1,  jl: 3,  bp: 2, ok: 1'b1, n: 3};
        tbl[3] = '{jf: 1,  jl: 14, bp: 1, ok: 1'b1, n: 14};
        tbl[4] = '{jf: 14, jl: 14, bp: 1, ok: 1'b1, n: 1};
        tbl[5] = '{jf: 5,  jl: 2,  bp: 0, ok: 1'b0, n: 0};
        tbl[6] = '{jf: 1,  jl: 15, bp: 0, ok: 1'b0, n: 0};
        tbl[7] = '{jf: 0,  jl: 3,  bp: 0, ok: 1'b0, n: 0};

        for (int k = 0; k < J * A; k++) alpha[k*64 +: 64] = $realtobits(real'(k + 1));
        for (int k = 0; k < J; k++) xsel[k*AW +: AW] = AW'(k % 2);

        // reset state
        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        rst_n = 1'b1;

        // reset while waiting for the engine
        @(negedge clk);
        job_tvalid = 1'b1; job_j_first = 5'd1; job_j_last = 5'd3;
        @(negedge clk);
        job_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_idle_outs("midjob_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_quiet", 64'({res_tvalid, eng_ind_j_tvalid, err}), 64'd0);
        end

        // spurious engine result while idle
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("spurious_err", 64'(err), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("err_cleared_by_reset", 64'(err), 64'd0);
        exp_err = 1'b0;

        foreach (tbl[t]) run_job(tbl[t].jf, tbl[t].jl, tbl[t].bp, tbl[t].ok, tbl[t].n);

        // random jobs, tables and backpressure
        for (int r = 0; r < 10; r++) begin
            int jf, jl;
            bit ok;
            for (int k = 0; k < J * A * 2; k++) alpha[k*32 +: 32] = $urandom;
            xsel = (J*AW)'({$urandom, $urandom});
            if ($urandom_range(0, 3) != 0) begin
                jf = $urandom_range(1, J);
                jl = $urandom_range(jf, J);
            end else begin
                jf = $urandom_range(0, 15);
                jl = $urandom_range(0, 15);
            end
            ok = (jf >= 1) && (jf <= jl) && (jl <= J);
            run_job(jf, jl, 1, ok, ok ? (jl - jf + 1) : 0);
        end

`ifdef BACKBONE_INITIAL_CTRL_TIMEOUT_EN
        silent_j = 2;
        run_job(1, 3, 0, 1'b1, 3);
        silent_j = -1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/backbone_initial_ctrl.md
Name: backbone_initial_ctrl

Overview:
- Sequencer in front of one backbone_initial engine (J=14, I=7, A=2).
- Accepts one job: the alpha_u table, the x_initial vector and an inclusive ind_j range [j_first, j_last].
- Drives the engine's three tvalid-qualified inputs once per ind_j and collects each 64-bit backbone_initial result.
- Emits the results in order as a ready/valid stream, so a downstream consumer can sweep ind_j without hand-pulsing the engine.

Parameters:
- J, 14, number of positions; ind_j is valid in 1..J.
- I, 7, passed through for consistency with the engine; not used internally.
- A, 2, alternatives per position.
- TIMEOUT_CYC, 64, cycles to wait for an engine result (used only with the optional feature).
- Derived localparams: J_WIDTH=$clog2(J)+1, A_WIDTH=$clog2(A)+1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- job_tvalid  in  1  job offered.
- job_tready  out  1  high only in IDLE.
- job_alpha_u  in  J*A*64  alpha table, IEEE-754 double.
- job_x_initial  in  J*A_WIDTH  per-position selection.
- job_j_first  in  J_WIDTH  first ind_j.
- job_j_last  in  J_WIDTH  last ind_j, inclusive.
- eng_alpha_u  out  J*A*64  latched table to engine.
- eng_alpha_u_tvalid  out  1  one-cycle issue pulse.
- eng_x_initial  out  J*A_WIDTH  latched selection to engine.
- eng_x_initial_tvalid  out  1  same pulse as eng_alpha_u_tvalid.
- eng_ind_j  out  J_WIDTH  current index.
- eng_ind_j_tvalid  out  1  same pulse as eng_alpha_u_tvalid.
- eng_result_tvalid  in  1  engine backbone_initial_tvalid.
- eng_result  in  64  engine backbone_initial.
- res_tvalid  out  1  result available.
- res_tready  in  1  consumer accepts.
- res_data  out  64  result value.
- res_ind_j  out  J_WIDTH  ind_j that produced res_data.
- res_last  out  1  high with the result for j_last.
- busy  out  1  state != IDLE.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0 except job_tready=1.
  - Latched job registers 0; cur_j=0.
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - Job accepted on job_tvalid & job_tready; alpha_u, x_initial, j_first and j_last are latched.
  - Valid job: 1 <= j_first <= j_last <= J. Set cur_j=j_first and go to ISSUE.
  - Invalid job: consumed (handshake completes), err set, remain in IDLE, no engine pulse.
- ISSUE (exactly 1 cycle):
  - All three eng_*_tvalid =1 with eng_ind_j=cur_j; go to WAIT.
  - Issue pulse appears the cycle after job acceptance.
- WAIT:
  - On eng_result_tvalid, capture res_data=eng_result and res_ind_j=cur_j.
  - Set res_last=(cur_j==j_last), res_tvalid=1, go to OUT.
  - Result captured the same cycle it is presented (registered; visible next cycle).
- OUT:
  - res_tvalid and data held stable until res_tready.
  - On handshake with res_last=1: go to IDLE.
  - On handshake with res_last=0: cur_j+1, go to ISSUE.
  - A result already valid with res_tready high completes in one cycle.
- eng_alpha_u and eng_x_initial are driven from the latched registers continuously, stable for the whole job.
- eng_result_tvalid in any state other than WAIT: ignored, err set.
- Single-index job (j_first==j_last): one issue, one result with res_last=1.
- New job is never accepted while busy; job_tready=0 outside IDLE.
- Reset mid-job: immediate return to IDLE. The pending result is discarded and no further pulses are issued.

Optional Feature:
- Macro: BACKBONE_INITIAL_CTRL_TIMEOUT_EN.
- With the macro defined:
  - A counter starts at WAIT entry.
  - If TIMEOUT_CYC cycles elapse with no eng_result_tvalid, emit res_data=64'h7FF8000000000000 (quiet NaN) with the normal res_ind_j/res_last, set err, and go to OUT; the sweep continues.
  - A late result is then treated as spurious (err).
- Without the macro: WAIT is unbounded; there is no counter logic.

Decomposition:
- Package backbone_initial_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, OUT);
  - NaN constant;
  - width helper functions for J_WIDTH and A_WIDTH.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Common stub: engine answers 3 cycles after the ind_j pulse with value {ind_j as double}. alpha_u = 1.0..28.0; x_initial alternates 0/1.
- Sweep j_first=1, j_last=3, res_tready=1 -> three results 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000 with res_ind_j 1,2,3; res_last only on the third; busy drops the cycle after the third handshake.
- Single index j_first=j_last=7 -> exactly one issue pulse; res_data=64'h401C000000000000; res_last=1.
- Backpressure: res_tready=0 for 10 cycles on the first result -> res_data stable, no second issue pulse until the handshake.
- Invalid jobs: j_first=5, j_last=2, then j_last=15 -> each accepted in one cycle, err=1, no eng_*_tvalid ever asserted.
- Reset mid-job (rst_n low during WAIT) -> all outputs 0, job_tready=1; a subsequent valid job runs normally.
- With BACKBONE_INITIAL_CTRL_TIMEOUT_EN: stub silent for ind_j=2 -> after 64 cycles res_data=64'h7FF8000000000000, err=1; sweep continues to ind_j=3.
